f_d_latch_ctrl: RTL and testbench

Sequencer for the fetch-to-decode pipeline latch. It drives that latch's ld and clr, and drives the fetch stall. It tracks whether the latch holds a valid packet and resolves decode backpressure, branch-mispredict flushes and exception/interrupt flushes in a fixed priority. It holds fetch off while an exception packet drains, and it keeps saturating stall and flush performance counters.

---
 rtl/f_d_latch_ctrl_pkg.sv | 12 +
 rtl/f_d_latch_ctrl_if.sv | 22 ++
 rtl/f_d_latch_ctrl_sat_counter.sv | 28 ++
 rtl/f_d_latch_ctrl.sv | 131 +++++++++++++
 tb/tb_f_d_latch_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/f_d_latch_ctrl_pkg.sv
// Shared types and constants for the fetch-to-decode latch sequencer.
package f_d_latch_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_EXC_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/f_d_latch_ctrl_if.sv
// Fetch/decode handshake and latch-control signals of the F/D latch sequencer.
interface f_d_latch_ctrl_if;
  logic f_valid;
  logic f_IE;
  logic d_stall;
  logic br_flush;
  logic exc_flush;
  logic latch_ld;
  logic latch_clr;
  logic f_stall;
  logic occ;

  modport master (
    output f_valid, f_IE, d_stall, br_flush, exc_flush,
    input  latch_ld, latch_clr, f_stall, occ
  );

  modport slave (
    input  f_valid, f_IE, d_stall, br_flush, exc_flush,
    output latch_ld, latch_clr, f_stall, occ
  );
endinterface

// File: rtl/f_d_latch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Increment unless already at all-ones.
  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) q_d = q_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/f_d_latch_ctrl.sv
// Sequencer for the fetch-to-decode pipeline latch: load/clear, fetch stall,
// flush bubbles, exception drain hold and performance counters.
module f_d_latch_ctrl
  import f_d_latch_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned EXC_TIMEOUT  = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               clk,
  input  logic               clr,
  f_d_latch_ctrl_if.slave    bus,
  output logic [STATE_W-1:0] state,
  output logic               exc_timeout,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int unsigned BUB_W = 4;
  localparam int unsigned WD_W  = $clog2(EXC_TIMEOUT);

  state_e            state_q, state_d;
  logic              occ_q, occ_d;
  logic [BUB_W-1:0]  bub_q, bub_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_q, to_d;
  logic              ld_c, lclr_c, fst_c, flush_c;

  // Next-state and Mealy outputs; reset overrides flush, flush overrides the state action.
  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    bub_d   = bub_q;
    wd_d    = wd_q;
    to_d    = to_q;
    ld_c    = 1'b0;
    lclr_c  = 1'b0;
    fst_c   = 1'b0;
    flush_c = bus.exc_flush | (bus.br_flush & (state_q != ST_EXC_HOLD));

    case (state_q)
      ST_RUN: begin
        ld_c  = bus.f_valid & (~occ_q | ~bus.d_stall);
        fst_c = occ_q & bus.d_stall;
        wd_d  = '0;
        if (ld_c && bus.f_IE) state_d = ST_EXC_HOLD;
      end
      ST_FLUSH: begin
        lclr_c = 1'b1;
        wd_d   = '0;
        if (bub_q <= BUB_W'(1)) begin
          bub_d   = '0;
          state_d = ST_RUN;
        end else begin
          bub_d = bub_q - BUB_W'(1);
        end
      end
      ST_EXC_HOLD: begin
        fst_c  = 1'b1;
        lclr_c = occ_q & ~bus.d_stall;
        if (wd_q == WD_W'(EXC_TIMEOUT - 1)) to_d = 1'b1;
        else                                 wd_d = wd_q + WD_W'(1);
      end
      default: state_d = ST_RUN;
    endcase

    // Flush bubble count includes the flush cycle itself.
    if (flush_c) begin
      ld_c    = 1'b0;
      lclr_c  = 1'b1;
      fst_c   = 1'b0;
      bub_d   = BUB_W'(FLUSH_CYCLES - 1);
      wd_d    = '0;
      state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end

    if (lclr_c)    occ_d = 1'b0;
    else if (ld_c) occ_d = bus.f_valid;

    if (clr) begin
      ld_c    = 1'b0;
      lclr_c  = 1'b1;
      fst_c   = 1'b0;
      flush_c = 1'b0;
      state_d = ST_RUN;
      occ_d   = 1'b0;
      bub_d   = '0;
      wd_d    = '0;
      to_d    = 1'b0;
    end
  end

  // State, occupancy, bubble counter, watchdog and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_RUN;
      occ_q   <= 1'b0;
      bub_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      bub_q   <= bub_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (clr),
    .inc (fst_c),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (clr),
    .inc (flush_c),
    .q   (flush_cnt)
  );

  assign bus.latch_ld  = ld_c;
  assign bus.latch_clr = lclr_c;
  assign bus.f_stall   = fst_c;
  assign bus.occ       = occ_q;
  assign state         = state_q;
  assign exc_timeout   = to_q;

endmodule

// File: tb/tb_f_d_latch_ctrl.sv
// Self-checking bench for the F/D latch sequencer against a cycle-level behavioural model.
module tb_f_d_latch_ctrl;

  localparam int unsigned FC = 2;
  localparam int unsigned ET = 8;
  localparam int unsigned CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic clr;
  logic [1:0]    state;
  logic          exc_timeout;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  f_d_latch_ctrl_if ifc ();

  f_d_latch_ctrl #(.FLUSH_CYCLES(FC), .EXC_TIMEOUT(ET), .CNT_W(CW)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (ifc.slave),
    .state       (state),
    .exc_timeout (exc_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: pipeline situation described as plain facts, not an FSM.
  bit m_valid   = 0;
  bit m_in_exc  = 0;
  int m_bubbles = 0;
  bit m_occ     = 0;
  int m_wd      = 0;
  bit m_to      = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit c, input bit fv, input bit ie, input bit ds,
                       input bit br, input bit ex);
    bit fl, e_ld, e_clr, e_st;
    int e_state;
    clr = c;
    ifc.f_valid = fv; ifc.f_IE = ie; ifc.d_stall = ds;
    ifc.br_flush = br; ifc.exc_flush = ex;

    fl = ex || (br && !m_in_exc);
    e_ld = 0; e_clr = 0; e_st = 0;
    if (c || fl || m_bubbles > 0) e_clr = 1;
    else if (m_in_exc) begin
      e_st  = 1;
      e_clr = m_occ && !ds;
    end else begin
      e_ld = fv && (!m_occ || !ds);
      e_st = m_occ && ds;
    end
    e_state = m_in_exc ? 2 : (m_bubbles > 0 ? 1 : 0);

    @(negedge clk);
    chk("latch_ld",  32'(ifc.latch_ld),  32'(e_ld));
    chk("latch_clr", 32'(ifc.latch_clr), 32'(e_clr));
    chk("f_stall",   32'(ifc.f_stall),   32'(e_st));
    if (m_valid) begin
      chk("occ",         32'(ifc.occ),       32'(m_occ));
      chk("state",       32'(state),         32'(e_state));
      chk("exc_timeout", 32'(exc_timeout),   32'(m_to));
      chk("stall_cnt",   32'(stall_cnt),     32'(m_stalls));
      chk("flush_cnt",   32'(flush_cnt),     32'(m_flushes));
    end

    @(posedge clk);
    if (c) begin
      m_valid = 1; m_in_exc = 0; m_bubbles = 0; m_occ = 0;
      m_wd = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (e_st && m_stalls < CMAX) m_stalls++;
      if (fl && m_flushes < CMAX) m_flushes++;
      if (e_clr) m_occ = 0;
      else if (e_ld) m_occ = 1;
      if (fl) begin
        m_in_exc = 0; m_bubbles = FC - 1; m_wd = 0;
      end else if (m_bubbles > 0) begin
        m_bubbles--;
      end else if (m_in_exc) begin
        if (m_wd == ET - 1) m_to = 1;
        else m_wd++;
      end else if (e_ld && ie) begin
        m_in_exc = 1; m_wd = 0;
      end
    end
    #1;
  endtask

  initial begin
    clr = 1'b1;
    ifc.f_valid = 0; ifc.f_IE = 0; ifc.d_stall = 0;
    ifc.br_flush = 0; ifc.exc_flush = 0;
    #1;

    // Reset with fetch valid, then release.
    repeat (3) cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Backpressure on a full latch, then release.
    repeat (4) cycle(0, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Mispredict, then a second one landing inside the bubble.
    cycle(0, 1, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Empty latch absorbs under d_stall.
    cycle(0, 1, 0, 1, 0, 0);
    // Exception packet: hold, drain, ignored mispredict, exception flush.
    cycle(0, 1, 1, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 1);
    repeat (2) cycle(0, 1, 0, 0, 0, 0);
    // Watchdog expiry with no exception flush.
    cycle(0, 1, 1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, $urandom_range(0, 1) == 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    repeat (2) cycle(0, 1, 0, 0, 0, 0);
    // Both flushes together while stalled with fetch valid.
    cycle(0, 1, 0, 1, 1, 1);
    repeat (2) cycle(0, 1, 0, 0, 0, 0);
    // Saturate the stall counter.
    repeat (CMAX + 8) cycle(0, 1, 0, 1, 0, 0);
    // Reset in the middle of a flush and of an exception hold.
    cycle(0, 1, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 4,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
